debounce_bank: RTL
==================

// Module: debounce_bank
// PURPOSE
//  Multi-channel debouncer for the push-button/switch inputs feeding game control.
//  Per channel: synchronises the raw pin, rejects bounce shorter than NDELAY cycles,
//  and emits a clean level plus one-cycle rise/fall strobes.
//  Optional hold-to-repeat strobe for held direction keys.
//  Sits between top-level pads and the input/control FSM.
// PARAMETERS
//  NCH          5        number of independent channels
//  NDELAY       1200000  consecutive stable cycles required (24 ms @ 50 MHz); >=1
//  SYNC_STAGES  2        synchroniser flops per channel; >=2
//  REPEAT_DELAY 25000000 cycles of held-high clean before first repeat (only with DEBOUNCE_REPEAT_EN)
//  REPEAT_RATE  5000000  cycles between subsequent repeats (only with DEBOUNCE_REPEAT_EN)
// PORTS
//  Clk        in   1    system clock
//  Rst_n      in   1    asynchronous active-low reset
//  DataNoisy  in   NCH  raw asynchronous inputs, bit i = channel i
//  DataClean  out  NCH  debounced level
//  Rise       out  NCH  1-cycle strobe when DataClean[i] goes 0->1
//  Fall       out  NCH  1-cycle strobe when DataClean[i] goes 1->0
//  Repeat     out  NCH  1-cycle key-event strobe (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (Rst_n=0, async assert, sync deassert by the system): all sync flops,
//    sample, count, DataClean, Rise, Fall, Repeat, and repeat counters = 0.
//  - Sync: DataNoisy[i] passes through SYNC_STAGES flops -> s[i]. No logic on raw input.
//  - Per channel, every edge:
//      if s != sample       : sample <= s; count <= 0
//      else if count==NDELAY: if DataClean != sample -> DataClean <= sample, strobe
//      else                 : count <= count+1 (saturates at NDELAY)
//  - Count width CW = clog2(NDELAY+1); no wrap, count holds at NDELAY while stable.
//  - Latency: input stable from edge t -> DataClean changes at edge t+SYNC_STAGES+NDELAY+1.
//  - Rise/Fall are registered, asserted exactly in the cycle DataClean first shows the
//    new value, high for 1 cycle, mutually exclusive per channel.
//  - A toggle of s before count reaches NDELAY restarts count; DataClean unchanged;
//    no strobes. Pulses shorter than NDELAY cycles are never seen.
//  - Channels are fully independent; simultaneous events on several channels each
//    produce their own strobes in the same cycle.
//  - Input held high through reset release: DataClean rises (with Rise strobe)
//    SYNC_STAGES+NDELAY+1 cycles after deassertion.
//  - Reset mid-count or mid-repeat: all state is cleared immediately; strobes drop
//    in the same cycle.
// CONFIGURATION
//  Macro DEBOUNCE_REPEAT_EN:
//  - Defined: per-channel repeat counter (width clog2(max(REPEAT_DELAY,REPEAT_RATE)+1)).
//    - Repeat[i] pulses together with Rise[i].
//    - While DataClean[i] stays 1: next pulse REPEAT_DELAY cycles after Rise, then
//      every REPEAT_RATE cycles.
//    - Counter clears on Fall or while DataClean[i]=0.
//  - Undefined: Repeat = Rise (same strobe); no repeat counters; REPEAT_* ignored.
//  - Port list is identical in both builds.
// STRUCTURE
//  - Package debounce_pkg:
//    - clog2 function
//    - default NDELAY/REPEAT_* constants per clock (50 MHz, 25 MHz, sim:
//      NDELAY=4, REPEAT_DELAY=10, REPEAT_RATE=3)
//  - Sub-module debounce_chan: one channel (sync chain, sample, counter, strobes,
//    optional repeat).
//  - debounce_bank: generate loop of NCH debounce_chan instances.
// TESTING (sim constants: NDELAY=4, SYNC_STAGES=2, REPEAT_DELAY=10, REPEAT_RATE=3)
//  1. Ch0 0->1 held clean at edge t -> DataClean[0]=1 and Rise[0]=1 at edge t+7 only;
//     no Fall.
//  2. Ch1 bounces 1,0,1,0 (2 cycles each) then holds 1 -> exactly one Rise, 7 cycles
//     after last edge; DataClean never glitches.
//  3. Ch2 high for 3 cycles then low -> no DataClean change, no strobes.
//  4. All NCH channels toggle in the same cycle -> all Rise bits assert in the same
//     cycle; later release gives all Fall bits together.
//  5. Rst_n pulsed low while ch0 count=2 -> outputs 0 immediately; with input still
//     high, Rise 7 cycles after release.
//  6. REPEAT_EN: ch3 held -> Repeat at Rise, Rise+10, +13, +16...; release stops
//     pulses. Without the macro, Repeat==Rise every cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants and helpers for the input debouncer bank.
//   clog2()            - ceiling log2, minimum result 1 (sizes counters)
//   *_50MHZ / *_25MHZ  - NDELAY / REPEAT_* defaults for the board clocks
//   *_SIM              - shortened constants for simulation
package debounce_pkg;

    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    // 24 ms debounce, 500 ms first repeat, 100 ms repeat period
    localparam int unsigned NDELAY_50MHZ       = 1200000;
    localparam int unsigned REPEAT_DELAY_50MHZ = 25000000;
    localparam int unsigned REPEAT_RATE_50MHZ  = 5000000;

    localparam int unsigned NDELAY_25MHZ       = 600000;
    localparam int unsigned REPEAT_DELAY_25MHZ = 12500000;
    localparam int unsigned REPEAT_RATE_25MHZ  = 2500000;

    localparam int unsigned NDELAY_SIM         = 4;
    localparam int unsigned REPEAT_DELAY_SIM   = 10;
    localparam int unsigned REPEAT_RATE_SIM    = 3;

    // Number of bits needed to hold values 0..value-1; never less than 1.
    function automatic int unsigned clog2(input longint unsigned value);
        int unsigned      bits;
        longint unsigned  rem;
        bits = 0;
        rem  = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one debouncer channel.
//   Synchronises the raw pin, requires NDELAY consecutive stable synchronised
//   samples before updating the clean level, and emits registered one-cycle
//   Rise/Fall strobes in the cycle DataClean first shows the new value.
//   Build option DEBOUNCE_REPEAT_EN adds a hold-to-repeat strobe; without it
//   Repeat is the Rise strobe.
// Ports:
//   Clk        in   system clock
//   Rst_n      in   asynchronous active-low reset
//   DataNoisy  in   raw asynchronous pin
//   DataClean  out  debounced level
//   Rise/Fall  out  1-cycle edge strobes of DataClean
//   Repeat     out  1-cycle key-event strobe
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned NDELAY       = NDELAY_50MHZ,
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEFAULT,
    parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_50MHZ,
    parameter int unsigned REPEAT_RATE  = REPEAT_RATE_50MHZ
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic DataNoisy,
    output logic DataClean,
    output logic Rise,
    output logic Fall,
    output logic Repeat
);

    localparam int unsigned      CW        = clog2(NDELAY + 1);
    localparam logic [CW-1:0]    COUNT_MAX = CW'(NDELAY);

    if (NDELAY < 1) begin : g_bad_ndelay
        $error("debounce_chan: NDELAY must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_chan: SYNC_STAGES must be >= 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("debounce_chan: REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   sample;
    logic [CW-1:0]          count;
    logic                   upd;
    logic                   rise_now;
    logic                   fall_now;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], DataNoisy};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Clean level changes only when the sample has been stable for NDELAY
    // counted cycles and differs from the current clean level.
    always_comb begin
        upd      = (s == sample) && (count == COUNT_MAX) && (DataClean != sample);
        rise_now = upd & sample;
        fall_now = upd & ~sample;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sample    <= 1'b0;
            count     <= '0;
            DataClean <= 1'b0;
            Rise      <= 1'b0;
            Fall      <= 1'b0;
        end else begin
            Rise <= rise_now;
            Fall <= fall_now;
            if (s != sample) begin
                sample <= s;
                count  <= '0;
            end else if (count == COUNT_MAX) begin
                if (upd) begin
                    DataClean <= sample;
                end
            end else begin
                count <= count + CW'(1);
            end
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW   = clog2(RMAX + 1);

    logic [RW-1:0] rpt_cnt;

    // Down-counter: loaded with DELAY-1 on the rising edge so the first
    // repeat lands DELAY cycles after Rise, then reloaded with RATE-1.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rpt_cnt <= '0;
            Repeat  <= 1'b0;
        end else begin
            Repeat <= 1'b0;
            if (rise_now) begin
                Repeat  <= 1'b1;
                rpt_cnt <= RW'(REPEAT_DELAY - 1);
            end else if (!DataClean || fall_now) begin
                rpt_cnt <= '0;
            end else if (rpt_cnt == '0) begin
                Repeat  <= 1'b1;
                rpt_cnt <= RW'(REPEAT_RATE - 1);
            end else begin
                rpt_cnt <= rpt_cnt - RW'(1);
            end
        end
    end
`else
    assign Repeat = Rise;
`endif

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: NCH independent debouncer channels for buttons/switches.
//   Optional build macro: DEBOUNCE_REPEAT_EN (hold-to-repeat strobe).
// Ports:
//   Clk        in   system clock
//   Rst_n      in   asynchronous active-low reset
//   DataNoisy  in   [NCH] raw asynchronous inputs, bit i = channel i
//   DataClean  out  [NCH] debounced levels
//   Rise       out  [NCH] 1-cycle strobe on DataClean 0->1
//   Fall       out  [NCH] 1-cycle strobe on DataClean 1->0
//   Repeat     out  [NCH] 1-cycle key-event strobe (Rise, plus hold repeats)
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned NCH          = 5,
    parameter int unsigned NDELAY       = NDELAY_50MHZ,
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEFAULT,
    parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_50MHZ,
    parameter int unsigned REPEAT_RATE  = REPEAT_RATE_50MHZ
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic [NCH-1:0] DataNoisy,
    output logic [NCH-1:0] DataClean,
    output logic [NCH-1:0] Rise,
    output logic [NCH-1:0] Fall,
    output logic [NCH-1:0] Repeat
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        debounce_chan #(
            .NDELAY      (NDELAY),
            .SYNC_STAGES (SYNC_STAGES),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_chan (
            .Clk       (Clk),
            .Rst_n     (Rst_n),
            .DataNoisy (DataNoisy[i]),
            .DataClean (DataClean[i]),
            .Rise      (Rise[i]),
            .Fall      (Fall[i]),
            .Repeat    (Repeat[i])
        );
    end

endmodule
